// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants (IV, K table) and round helper functions.
package sha256_pkg;
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: combinational SHA-256 round, state is {a,b,c,d,e,f,g,h} with a in the top word.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] state_next
);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;

    assign {a, b, c, d, e, f, g, h} = state;
    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);
    assign state_next = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_compressor.sv
// sha256_compressor: one SHA-256 round per clock on registered a..h, reloaded from H0..H7 on reset.
// Defining COMPRESSOR_DIGEST_EN adds the feed-forward DIGEST0..7 registers and DONE flag.
module sha256_compressor
    import sha256_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [5:0]  I,
    input  logic [31:0] W_IN,
    input  logic [31:0] K_IN,
    input  logic [31:0] H0, H1, H2, H3, H4, H5, H6, H7,
    output logic [31:0] a, b, c, d, e, f, g, h
`ifdef COMPRESSOR_DIGEST_EN
    ,
    output logic [31:0] DIGEST0, DIGEST1, DIGEST2, DIGEST3,
    output logic [31:0] DIGEST4, DIGEST5, DIGEST6, DIGEST7,
    output logic        DONE
`endif
);
    logic [255:0] state_next;

    sha256_round u_round (
        .state      ({a, b, c, d, e, f, g, h}),
        .w          (W_IN),
        .k          (K_IN),
        .state_next (state_next)
    );

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET)
            {a, b, c, d, e, f, g, h} <= {H0, H1, H2, H3, H4, H5, H6, H7};
        else
            {a, b, c, d, e, f, g, h} <= state_next;

`ifdef COMPRESSOR_DIGEST_EN
    logic [255:0] hs, digest;

    assign hs = {H0, H1, H2, H3, H4, H5, H6, H7};
    assign {DIGEST0, DIGEST1, DIGEST2, DIGEST3, DIGEST4, DIGEST5, DIGEST6, DIGEST7} = digest;

    // Digest is taken from the round-63 result as it is being registered, so it lands on the same edge.
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            digest <= '0;
            DONE   <= 1'b0;
        end else if (I == 6'd63) begin
            for (int j = 0; j < 8; j++)
                digest[32*j +: 32] <= hs[32*j +: 32] + state_next[32*j +: 32];
            DONE <= 1'b1;
        end else if (I == 6'd0)
            DONE <= 1'b0;
`else
    logic unused_i;
    assign unused_i = ^I;
`endif
endmodule

// File: tb/tb_sha256_compressor.sv
// tb_sha256_compressor: table-driven single rounds plus full-block sequences checked against an arithmetic SHA-256 model.
module tb_sha256_compressor;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [5:0]  I = '0;
    logic [31:0] W_IN = '0, K_IN = '0;
    logic [31:0] H0, H1, H2, H3, H4, H5, H6, H7;
    logic [31:0] a, b, c, d, e, f, g, h;
`ifdef COMPRESSOR_DIGEST_EN
    logic [31:0] DIGEST0, DIGEST1, DIGEST2, DIGEST3, DIGEST4, DIGEST5, DIGEST6, DIGEST7;
    logic        DONE;
`endif

    sha256_compressor dut (
        .CLK(CLK), .RESET(RESET), .I(I), .W_IN(W_IN), .K_IN(K_IN),
        .H0(H0), .H1(H1), .H2(H2), .H3(H3), .H4(H4), .H5(H5), .H6(H6), .H7(H7),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h)
`ifdef COMPRESSOR_DIGEST_EN
        ,
        .DIGEST0(DIGEST0), .DIGEST1(DIGEST1), .DIGEST2(DIGEST2), .DIGEST3(DIGEST3),
        .DIGEST4(DIGEST4), .DIGEST5(DIGEST5), .DIGEST6(DIGEST6), .DIGEST7(DIGEST7),
        .DONE(DONE)
`endif
    );

    always #5 CLK = ~CLK;

    localparam logic [255:0] IV_S = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    logic [31:0] kref [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct packed {
        logic [255:0] hs;
        logic [31:0]  w;
        logic [31:0]  k;
        logic [255:0] exp;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] w_sched [64];
    logic [255:0] ref_s;
    int          n_pass = 0, n_total = 0;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] dd = {x, x} >> n;
        return dd[31:0];
    endfunction

    function automatic logic [255:0] ref_round(input logic [255:0] s, input logic [31:0] wv, input logic [31:0] kv);
        logic [31:0] v [8];
        logic [31:0] s1, s0, chv, mj;
        logic [63:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = s[255-32*i -: 32];
        s1  = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
        chv = (v[4] & v[5]) | (~v[4] & v[6]);
        s0  = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
        mj  = (v[0] & v[1]) | (v[2] & (v[0] | v[1]));
        t1  = (64'(v[7]) + 64'(s1) + 64'(chv) + 64'(kv) + 64'(wv)) % 64'h1_0000_0000;
        t2  = (64'(s0) + 64'(mj)) % 64'h1_0000_0000;
        for (int i = 7; i > 0; i--) v[i] = v[i-1];
        v[4] = 32'((64'(v[4]) + t1) % 64'h1_0000_0000);
        v[0] = 32'((t1 + t2) % 64'h1_0000_0000);
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = 32'((64'(x[32*i +: 32]) + 64'(y[32*i +: 32])) % 64'h1_0000_0000);
        return r;
    endfunction

    task automatic make_sched(input logic [511:0] m);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w_sched[t] = m[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w_sched[t-15], 7) ^ rr(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3);
            s1 = rr(w_sched[t-2], 17) ^ rr(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10);
            w_sched[t] = 32'((64'(w_sched[t-16]) + 64'(s0) + 64'(w_sched[t-7]) + 64'(s1)) % 64'h1_0000_0000);
        end
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [255:0] dut_state();
        return {a, b, c, d, e, f, g, h};
    endfunction

    task automatic set_h(input logic [255:0] hs);
        {H0, H1, H2, H3, H4, H5, H6, H7} = hs;
    endtask

    task automatic start_block(input logic [255:0] hs, input string tag);
        RESET = 1'b0;
        set_h(hs);
        @(negedge CLK);
        chk({tag, " reset"}, dut_state(), hs);
        RESET = 1'b1;
        ref_s = hs;
    endtask

    task automatic run_rounds(input int n, input string tag);
        for (int r = 0; r < n; r++) begin
            I = 6'(r);
            W_IN = w_sched[r];
            K_IN = kref[r];
            @(negedge CLK);
            ref_s = ref_round(ref_s, w_sched[r], kref[r]);
            chk($sformatf("%s r%0d", tag, r), dut_state(), ref_s);
        end
    endtask

    initial begin
        logic [255:0] hs;
        set_h(IV_S);
        tbl[0] = '{IV_S, 32'h61626380, 32'h428a2f98,
                   {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                    32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab}};
        tbl[1] = '{{256{1'b1}}, 32'hffffffff, 32'hffffffff, ref_round({256{1'b1}}, 32'hffffffff, 32'hffffffff)};
        for (int i = 2; i < 6; i++) begin
            tbl[i].hs  = rand256();
            tbl[i].w   = $urandom();
            tbl[i].k   = $urandom();
            tbl[i].exp = ref_round(tbl[i].hs, tbl[i].w, tbl[i].k);
        end
        @(negedge CLK);
`ifdef COMPRESSOR_DIGEST_EN
        chk("done after reset", 256'(DONE), 256'(0));
        chk("digest0 after reset", 256'(DIGEST0), 256'(0));
`endif
        for (int i = 0; i < 6; i++) begin
            start_block(tbl[i].hs, $sformatf("tbl%0d", i));
            I = 6'd0;
            W_IN = tbl[i].w;
            K_IN = tbl[i].k;
            @(negedge CLK);
            chk($sformatf("tbl%0d round0", i), dut_state(), tbl[i].exp);
        end

        make_sched({32'h61626380, 448'h0, 32'h00000018});
        start_block(IV_S, "abc");
        run_rounds(64, "abc");
        chk("abc feed-forward", add_words(dut_state(), IV_S), ABC_DIGEST);
`ifdef COMPRESSOR_DIGEST_EN
        chk("abc digest", {DIGEST0, DIGEST1, DIGEST2, DIGEST3, DIGEST4, DIGEST5, DIGEST6, DIGEST7}, ABC_DIGEST);
        chk("abc done", 256'(DONE), 256'(1));
        I = 6'd0;
        W_IN = '0;
        K_IN = kref[0];
        @(negedge CLK);
        chk("done cleared at round 0", 256'(DONE), 256'(0));
        chk("digest held", 256'(DIGEST0), 256'(32'hba7816bf));
`endif

        make_sched({32'h48656c6c, 32'h6f20776f, 32'h726c6421, 32'h80000000, 352'h0, 32'h00000060});
        start_block(IV_S, "hello");
        run_rounds(64, "hello");

        hs = rand256();
        make_sched({rand256(), rand256()});
        start_block(hs, "midrst");
        run_rounds(30, "midrst");
        #2 RESET = 1'b0;
        #1 chk("async reset immediate", dut_state(), hs);
        @(negedge CLK);
        chk("reset held over edge", dut_state(), hs);
        RESET = 1'b1;
        ref_s = hs;
        run_rounds(64, "restart");

        for (int t = 0; t < 64; t++) w_sched[t] = 32'hffffffff;
        start_block({256{1'b1}}, "ovf");
        run_rounds(64, "ovf");
        chk("ovf no X", 256'($isunknown(dut_state())), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sha256_compressor.md
# sha256_compressor

SHA-256 compression core. It performs one compression round per clock on the eight working variables a..h. The round index, message-schedule word W and round constant K are supplied by an external round counter and memories. It sits between the message scheduler / K-ROM and the hash-state (H) registers of the SHA-256 datapath.

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset. Only one clock domain is used.
- I  in  6  current round index 0..63, driven by the external counter. Used only by the optional digest logic.
- W_IN  in  32  message-schedule word W[I] for the current round.
- K_IN  in  32  round constant K[I] for the current round.
- H0..H7  in  32 each  current hash state; loaded into a..h on reset.
- a, b, c, d, e, f, g, h  out  32 each  registered working variables.

## Operation
- Reset (RESET=0, asynchronous): a..h <= H0..H7 respectively. This holds while RESET is low.
- Every rising CLK edge with RESET high executes one SHA-256 round. All arithmetic is modulo 2^32 and purely combinational from the current registers, W_IN and K_IN:
  - S1 = ROTR6(e) ^ ROTR11(e) ^ ROTR25(e)
  - ch = (e & f) ^ (~e & g)
  - T1 = h + S1 + ch + K_IN + W_IN
  - S0 = ROTR2(a) ^ ROTR13(a) ^ ROTR22(a)
  - maj = (a & b) ^ (a & c) ^ (b & c)
  - T2 = S0 + maj
  - Next state: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
- There is no enable and no internal round counter. The block rounds on every clock until reset.
- Sequencing across the 64 rounds is the caller's job: it presents W[I] and K[I] for round I in the cycle that round executes.
- Reset asserted mid-block: the state is immediately discarded and reloaded from H0..H7. When RESET is released, the next rising edge executes a round using the W_IN/K_IN present on that edge.
- Carries beyond bit 31 are discarded. There is no saturation.

## Timing
- Latency: 1 cycle per round. After reset release, round n's result is visible on a..h after the (n+1)th rising edge.
- A full block takes 64 cycles after reset release.
- Outputs are glitch-free register outputs. The reset value is H0..H7 as sampled during reset.
- W_IN and K_IN must be stable at setup before each rising edge.

## Configuration
- COMPRESSOR_DIGEST_EN defined:
  - Adds outputs DIGEST0..DIGEST7 (out, 32 each) and DONE (out, 1).
  - On the edge executing round I==63, the block registers DIGESTn <= Hn + next_var_n (mod 2^32) and sets DONE=1.
  - DONE clears on reset and on the edge executing round I==0.
  - Reset values: DIGESTn=0, DONE=0.
- COMPRESSOR_DIGEST_EN undefined: these ports and registers are absent. The feed-forward add is the caller's job.

## Structure
- Shared package sha256_pkg holds:
  - the IV constants (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19);
  - the K table;
  - the functions rotr, big_sigma0, big_sigma1, ch and maj.
- One combinational sub-module, sha256_round, maps (a..h, W, K) to the next (a..h). The top module adds the registers, reset and optional digest.

## Test plan
- Reset with H = IV -> a..h = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- H = IV, round 0 with W_IN=61626380 ("abc" padded), K_IN=428a2f98 -> a..h = 5d6aebcd 6a09e667 bb67ae85 3c6ef372 fa2a4622 510e527f 9b05688c 1f83d9ab.
- Full "abc" block, 64 rounds with W/K from a reference model -> with COMPRESSOR_DIGEST_EN, DIGEST0..7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad and DONE=1.
- Full "Hello world!" block (W0=48656c6c, W1=6f20776f, W2=726c6421, W3=80000000, W15=00000060) -> a..h match the software model after each of the 64 rounds.
- Reset asserted at round 30 -> a..h immediately equal H0..H7. After release, rounds restart and match the model from round 0.
- Overflow stress: H and W all ffffffff -> results match the mod-2^32 model with no X or extra carry bits.
